// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle for serial_add_ctrl. The 'sub' wire exists only
// when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output ready, busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks the operands LSB-first.
// Defining SERIAL_ADD_SUB_EN adds a 'sub' input that computes a - b instead.
module fadder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, s_sr_reg, sum_reg;
  logic [WIDTH-1:0] s_shift;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg, cout_reg;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  assign bus.ready = (state_reg == IDLE) || (state_reg == DONE);
  assign bus.busy  = (state_reg == RUN);
  assign bus.done  = (state_reg == DONE);
  assign bus.sum   = sum_reg;
  assign bus.cout  = cout_reg;

  assign accept   = bus.start && bus.ready;
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  fadder u_fa (
    .a   (a_sr_reg[0]),
    .b   (b_sr_reg[0]),
    .cin (carry_reg),
    .s   (fa_s),
    .cout(fa_co)
  );

  // Result register shifts right; the new bit enters at the MSB.
  assign s_shift[WIDTH-1] = fa_s;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign s_shift[gi] = s_sr_reg[gi+1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      s_sr_reg  <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_sr_reg <= bus.a;
      cnt_reg  <= '0;
`ifdef SERIAL_ADD_SUB_EN
      // Two's-complement subtract: invert b and force the carry-in.
      b_sr_reg  <= bus.sub ? ~bus.b : bus.b;
      carry_reg <= bus.sub | bus.cin;
`else
      b_sr_reg  <= bus.b;
      carry_reg <= bus.cin;
`endif
    end else if (state_reg == RUN) begin
      a_sr_reg  <= a_sr_reg >> 1;
      b_sr_reg  <= b_sr_reg >> 1;
      s_sr_reg  <= s_shift;
      carry_reg <= fa_co;
      cnt_reg   <= cnt_reg + CW'(1);
      if (last_bit) begin
        sum_reg  <= s_shift;
        cout_reg <= fa_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes expected results, a
// negedge monitor checks done timing, busy/ready and result stability.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acc = 0;
  logic sub_v = 1'b0;

  logic [W:0] q_val[$];
  int         q_cyc[$];
  logic [W:0] last_res = '0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the definition of add / subtract.
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic ci, input logic sb);
    longint unsigned r;
    if (sb) r = longint'(av) + (longint'(1) << W) - longint'(bv);
    else    r = longint'(av) + longint'(bv) + longint'(ci);
    return r[W:0];
  endfunction

  // One clock of stimulus; records an accept if ready was high at the edge.
  task automatic step(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci);
    logic rdy;
    @(negedge clk);
    bus.start = s;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = sub_v;
`endif
    rdy = bus.ready;
    @(posedge clk);
    #1;
    if (s && rdy) begin
      q_val.push_back(model(av, bv, ci, sub_v));
      q_cyc.push_back(cyc);
      n_acc++;
      $display("accept a=%02h b=%02h cin=%0d sub=%0d expect=%03h cycle=%0d",
               av, bv, ci, sub_v, model(av, bv, ci, sub_v), cyc);
    end
  endtask

  task automatic idle_step();
    step(1'b0, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while (q_val.size() > 0 && n < 100) begin
      idle_step();
      n++;
    end
    check("drain_timeout", 64'(q_val.size()), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    step(1'b1, av, bv, ci);
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd1);
    q_val.delete();
    q_cyc.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: done must appear exactly W cycles after the accepting edge.
  always @(negedge clk) begin
    logic done_exp;
    logic busy_exp;
    if (rst) begin
      last_res = '0;
    end else begin
      done_exp = (q_cyc.size() > 0) && (cyc >= q_cyc[0] + W);
      busy_exp = (q_cyc.size() > 0) && !done_exp;
      check("done", 64'(bus.done), 64'(done_exp));
      check("busy", 64'(bus.busy), 64'(busy_exp));
      check("ready", 64'(bus.ready), 64'(!busy_exp));
      if (done_exp) begin
        check("result", 64'({bus.cout, bus.sum}), 64'(q_val[0]));
        $display("done cout=%0d sum=%02h expect=%03h cycle=%0d", bus.cout, bus.sum, q_val[0], cyc);
        last_res = q_val[0];
        void'(q_val.pop_front());
        void'(q_cyc.pop_front());
      end else begin
        check("result_hold", 64'({bus.cout, bus.sum}), 64'(last_res));
      end
    end
  end

  initial begin
    int acc0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    #3;
    do_reset();

    // Directed cases from the block's arithmetic corners.
    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1);
    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);

    // start during RUN is ignored.
    step(1'b1, 8'h33, 8'h44, 1'b0);
    idle_step();
    idle_step();
    step(1'b1, 8'h11, 8'h22, 1'b0);
    drain();
    repeat (3) idle_step();

    // Reset mid-RUN aborts the operation.
    step(1'b1, 8'h55, 8'hAA, 1'b1);
    repeat (3) idle_step();
    do_reset();
    run_op(8'h01, 8'h02, 1'b0);

    // start held high: back-to-back every W+1 cycles.
    acc0 = n_acc;
    repeat (3 * (W + 1)) step(1'b1, 8'h10, 8'h20, 1'b0);
    check("held_start_accepts", 64'(n_acc - acc0), 64'd3);
    drain();

`ifdef SERIAL_ADD_SUB_EN
    sub_v = 1'b1;
    run_op(8'h05, 8'h07, 1'b0);
    run_op(8'h07, 8'h05, 1'b0);
    run_op(8'h00, 8'h00, 1'b0);
    sub_v = 1'b0;
`endif

    // Random operations with noisy start during RUN and random gaps.
    for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      sub_v = 1'($urandom);
`endif
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom));
      for (int k = 0; k < W; k++)
        step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) idle_step();
    end
    sub_v = 1'b0;
    drain();
    repeat (3) idle_step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
